trena_uc: RTL and testbench
===========================

TRENA_UC -- requirements
Module: trena_uc

Interface
REQ-001 SHALL have parameter TIMEOUT_CICLOS, default 2500000, echo-wait limit in clock cycles (50 ms at 50 MHz).
REQ-002 SHALL have port clock  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port mensurar  input  1  start request; a one-cycle pulse suffices.
REQ-005 SHALL have port fim_medida  input  1  sensor-interface "measurement ready" pulse.
REQ-006 SHALL have port fim_envio  input  1  serial-transmitter "character sent" pulse.
REQ-007 SHALL have port zera  output  1  clears the datapath.
REQ-008 SHALL have port medir  output  1  one-cycle trigger request to the sensor interface.
REQ-009 SHALL have port registra  output  1  latches the 12-bit BCD measurement.
REQ-010 SHALL have port partida  output  1  one-cycle start for the serial transmitter.
REQ-011 SHALL have port conta  output  1  advance pulse for the digit counter.
REQ-012 SHALL have port sel_digito  output  2  mux select: 2=hundreds, 1=tens, 0=units, 3='#'.
REQ-013 SHALL have port pronto  output  1  one-cycle completion pulse.
REQ-014 SHALL have port erro  output  1  echo timeout flag.
REQ-015 SHALL have port db_estado  output  4  current state code.

Function
REQ-016 SHALL be a Moore FSM; outputs depend only on state and registers.
REQ-017 SHALL use these state codes, with the only outputs asserted in each: INICIAL=0 (none); PREPARA=1 (zera); MEDE=2 (medir); AGUARDA_MEDIDA=3 (none); REGISTRA=4 (registra); TRANSMITE=5 (partida); AGUARDA_ENVIO=6 (none); PROXIMO=7 (conta); FINAL=8 (pronto); ERRO=15 (erro).
REQ-018 SHALL implement these transitions:
- INICIAL -> PREPARA on mensurar.
- PREPARA -> MEDE.
- MEDE -> AGUARDA_MEDIDA.
REQ-019 SHALL leave AGUARDA_MEDIDA as follows:
- fim_medida=1 -> REGISTRA.
- otherwise, timer = TIMEOUT_CICLOS-1 -> ERRO.
- otherwise hold.
REQ-020 SHALL go REGISTRA -> TRANSMITE, and TRANSMITE -> AGUARDA_ENVIO.
REQ-021 SHALL leave AGUARDA_ENVIO on fim_envio=1: to FINAL if sel_digito=3, else to PROXIMO; otherwise hold.
REQ-022 SHALL go PROXIMO -> TRANSMITE, stepping sel_digito 2->1, 1->0, 0->3.
REQ-023 SHALL go FINAL -> INICIAL after exactly one cycle.
REQ-024 SHALL hold ERRO until mensurar=1, then go to PREPARA.
REQ-025 SHALL load sel_digito=2 in PREPARA, so transmission order is hundreds, tens, units, '#', i.e. exactly 4 partida pulses per measurement.
REQ-026 SHALL clear the timeout timer in MEDE and increment it by 1 per cycle only in AGUARDA_MEDIDA; the timer never wraps.
REQ-027 SHALL give fim_medida priority over the timeout when both occur in the same cycle.
REQ-028 SHALL ignore mensurar in every state except INICIAL and ERRO; a pulse during a measurement or transmission is dropped, not queued.
REQ-029 SHALL ignore fim_medida outside AGUARDA_MEDIDA, and fim_envio outside AGUARDA_ENVIO.
REQ-030 SHALL produce latencies of: mensurar to medir 2 cycles; fim_medida to registra 1 cycle; fim_envio to the next partida 2 cycles.

Reset
REQ-031 SHALL, when reset=0 at a rising clock edge, force state INICIAL, sel_digito=2, timer=0, and all strobes plus erro to 0; db_estado then reads 0.
REQ-032 SHALL let reset abort any state, including a transmission in progress, with no further partida issued.

Structure
REQ-033 SHALL take the state encodings and the sel_digito codes (SEL_CENTENA=2, SEL_DEZENA=1, SEL_UNIDADE=0, SEL_TERMINADOR=3) from shared package trena_pkg.
REQ-034 SHALL place the timeout timer in sub-module temporizador_uc (clear, enable, parameterized limit, fim output); the FSM and digit sequencing remain in trena_uc.

Verification (TIMEOUT_CICLOS=100)
REQ-035 SHALL cover the nominal sequence: pulse mensurar, fim_medida 20 cycles after medir, fim_envio 10 cycles after each partida -> state trace 1,2,3,4,5,6,7,5,6,7,5,6,7,5,6,8,0; sel_digito sequence 2,1,0,3; exactly 4 partida pulses, 3 conta pulses, 1 pronto pulse.
REQ-036 SHALL cover the timeout: no fim_medida -> erro=1 and db_estado=15 exactly 100 cycles after entering AGUARDA_MEDIDA, with no registra; a subsequent mensurar -> zera then medir, and erro drops.
REQ-037 SHALL cover the simultaneous case: fim_medida on the same cycle the timer reaches 99 -> REGISTRA, and erro stays 0.
REQ-038 SHALL cover a spurious start: mensurar pulsed in AGUARDA_ENVIO -> no state change and no extra zera or medir.
REQ-039 SHALL cover reset mid-operation: reset=0 for 1 cycle during the second AGUARDA_ENVIO -> next cycle db_estado=0, sel_digito=2, no partida until a new mensurar.
REQ-040 SHALL cover a stray pulse: fim_envio pulsed in INICIAL -> no state change.

Source files
------------

// File: rtl/trena_pkg.sv
// trena_pkg: shared FSM state codes and digit-select codes for the trena control unit
package trena_pkg;
  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    PREPARA        = 4'd1,
    MEDE           = 4'd2,
    AGUARDA_MEDIDA = 4'd3,
    REGISTRA       = 4'd4,
    TRANSMITE      = 4'd5,
    AGUARDA_ENVIO  = 4'd6,
    PROXIMO        = 4'd7,
    FINAL          = 4'd8,
    ERRO           = 4'd15
  } estado_t;
  localparam logic [1:0] SEL_CENTENA    = 2'd2;
  localparam logic [1:0] SEL_DEZENA     = 2'd1;
  localparam logic [1:0] SEL_UNIDADE    = 2'd0;
  localparam logic [1:0] SEL_TERMINADOR = 2'd3;
  function automatic logic [1:0] proximo_digito(input logic [1:0] sel);
    return sel == SEL_CENTENA ? SEL_DEZENA : sel == SEL_DEZENA ? SEL_UNIDADE : SEL_TERMINADOR;
  endfunction
endpackage

// File: rtl/temporizador_uc.sv
// temporizador_uc: saturating echo-wait timer; fim_o flags the last allowed cycle
module temporizador_uc #(
  parameter int LIMITE = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic zera_i,
  input  logic conta_i,
  output logic fim_o
);
  localparam int W = $clog2(LIMITE + 1);
  logic [W-1:0] cnt_q;
  assign fim_o = cnt_q == W'(LIMITE - 1);
  // holds at the limit instead of wrapping
  always_ff @(posedge clock) begin
    if (!reset || zera_i) cnt_q <= '0;
    else if (conta_i && !fim_o) cnt_q <= cnt_q + 1'b1;
  end
endmodule

// File: rtl/trena_uc.sv
// trena_uc: Moore control unit sequencing one ultrasonic measurement and its 4-char serial report
module trena_uc
  import trena_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = 2500000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mensurar,
  input  logic       fim_medida,
  input  logic       fim_envio,
  output logic       zera,
  output logic       medir,
  output logic       registra,
  output logic       partida,
  output logic       conta,
  output logic [1:0] sel_digito,
  output logic       pronto,
  output logic       erro,
  output logic [3:0] db_estado
);
  estado_t state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic zera_q, medir_q, registra_q, partida_q, conta_q, pronto_q, erro_q;
  logic tempo_fim;
  temporizador_uc #(.LIMITE(TIMEOUT_CICLOS)) u_tempo (
    .clock   (clock),
    .reset   (reset),
    .zera_i  (state_q == MEDE),
    .conta_i (state_q == AGUARDA_MEDIDA),
    .fim_o   (tempo_fim)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      INICIAL:        state_d = mensurar ? PREPARA : INICIAL;
      PREPARA:        state_d = MEDE;
      MEDE:           state_d = AGUARDA_MEDIDA;
      AGUARDA_MEDIDA: state_d = fim_medida ? REGISTRA : tempo_fim ? ERRO : AGUARDA_MEDIDA;
      REGISTRA:       state_d = TRANSMITE;
      TRANSMITE:      state_d = AGUARDA_ENVIO;
      AGUARDA_ENVIO:  state_d = !fim_envio ? AGUARDA_ENVIO : sel_q == SEL_TERMINADOR ? FINAL : PROXIMO;
      PROXIMO:        state_d = TRANSMITE;
      FINAL:          state_d = INICIAL;
      ERRO:           state_d = mensurar ? PREPARA : ERRO;
      default:        state_d = INICIAL;
    endcase
  end
  assign sel_d = state_q == PREPARA ? SEL_CENTENA : state_q == PROXIMO ? proximo_digito(sel_q) : sel_q;
  // strobes are registered from the next state so they line up with the state they belong to
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= INICIAL;
      sel_q      <= SEL_CENTENA;
      zera_q     <= 1'b0;
      medir_q    <= 1'b0;
      registra_q <= 1'b0;
      partida_q  <= 1'b0;
      conta_q    <= 1'b0;
      pronto_q   <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      zera_q     <= state_d == PREPARA;
      medir_q    <= state_d == MEDE;
      registra_q <= state_d == REGISTRA;
      partida_q  <= state_d == TRANSMITE;
      conta_q    <= state_d == PROXIMO;
      pronto_q   <= state_d == FINAL;
      erro_q     <= state_d == ERRO;
    end
  end
  assign zera       = zera_q;
  assign medir      = medir_q;
  assign registra   = registra_q;
  assign partida    = partida_q;
  assign conta      = conta_q;
  assign pronto     = pronto_q;
  assign erro       = erro_q;
  assign sel_digito = sel_q;
  assign db_estado  = state_q;
endmodule

// File: tb/tb_trena_uc.sv
// tb_trena_uc: scenario tasks for trena_uc with a state/strobe scoreboard, TIMEOUT_CICLOS=100
module tb_trena_uc;
  logic clock = 1'b0, reset = 1'b0, mensurar = 1'b0, fim_medida = 1'b0, fim_envio = 1'b0;
  logic zera, medir, registra, partida, conta, pronto, erro;
  logic [1:0] sel_digito;
  logic [3:0] db_estado;
  int n_cmp = 0, n_err = 0, cyc = 0;
  int n_zera = 0, n_medir = 0, n_registra = 0, n_partida = 0, n_conta = 0, n_pronto = 0, n_erro = 0;
  logic [6:0] exp_q[$];
  logic [1:0] exp_sel[$];

  trena_uc #(.TIMEOUT_CICLOS(100)) dut (
    .clock(clock), .reset(reset), .mensurar(mensurar), .fim_medida(fim_medida),
    .fim_envio(fim_envio), .zera(zera), .medir(medir), .registra(registra),
    .partida(partida), .conta(conta), .sel_digito(sel_digito), .pronto(pronto),
    .erro(erro), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc        <= cyc + 1;
    n_zera     <= n_zera + int'(zera);
    n_medir    <= n_medir + int'(medir);
    n_registra <= n_registra + int'(registra);
    n_partida  <= n_partida + int'(partida);
    n_conta    <= n_conta + int'(conta);
    n_pronto   <= n_pronto + int'(pronto);
    n_erro     <= n_erro + int'(erro);
  end

  task automatic wait_state(input logic [3:0] s, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge clock);
      ok = db_estado === s;
    end
  endtask

  task automatic finish_tx(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clock);
      fim_envio = db_estado === 4'd6;
      ok = db_estado === 4'd0;
    end
    fim_envio = 1'b0;
  endtask

  task automatic start_and_measure(output bit ok);
    @(negedge clock);
    mensurar = 1'b1;
    @(negedge clock);
    mensurar = 1'b0;
    wait_state(4'd3, 10, ok);
    fim_medida = 1'b1;
    @(negedge clock);
    fim_medida = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp += 3;
    if (db_estado !== 4'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", db_estado); end
    if (sel_digito !== 2'd2) begin n_err++; $display("FAIL reset_sel: got %0d want 2", sel_digito); end
    if ({zera, medir, registra, partida, conta, pronto, erro} !== 7'd0) begin
      n_err++; $display("FAIL reset_strobes: got %b want 0000000", {zera, medir, registra, partida, conta, pronto, erro});
    end
    reset = 1'b1;
  endtask

  task automatic test_stray();
    int p0;
    p0 = n_partida;
    @(negedge clock);
    fim_envio = 1'b1;
    fim_medida = 1'b1;
    @(negedge clock);
    fim_envio = 1'b0;
    fim_medida = 1'b0;
    n_cmp++;
    if (db_estado !== 4'd0) begin n_err++; $display("FAIL stray_state: got %0d want 0", db_estado); end
    repeat (3) @(negedge clock);
    n_cmp += 2;
    if (db_estado !== 4'd0) begin n_err++; $display("FAIL stray_hold: got %0d want 0", db_estado); end
    if (n_partida !== p0) begin n_err++; $display("FAIL stray_partida: got %0d want %0d", n_partida, p0); end
  endtask

  task automatic test_nominal();
    int trace[17] = '{1, 2, 3, 4, 5, 6, 7, 5, 6, 7, 5, 6, 7, 5, 6, 8, 0};
    logic [1:0] sels[4] = '{2'd2, 2'd1, 2'd0, 2'd3};
    int cd_med, cd_env, t_mens, t_med, t_env, p0, c0, r0;
    logic [3:0] prev;
    logic [6:0] got, want;
    logic [1:0] ws;
    cd_med = 0; cd_env = 0; t_med = -1; t_env = -1;
    p0 = n_partida; c0 = n_conta; r0 = n_pronto;
    foreach (trace[i]) exp_q.push_back({4'(trace[i]), trace[i] == 1, trace[i] == 2, 1'b0});
    foreach (sels[i]) exp_sel.push_back(sels[i]);
    @(negedge clock);
    prev = db_estado;
    mensurar = 1'b1;
    t_mens = cyc;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      @(negedge clock);
      mensurar = 1'b0;
      fim_medida = 1'b0;
      fim_envio = 1'b0;
      if (cd_med > 0) begin
        cd_med--;
        if (cd_med == 0) begin fim_medida = 1'b1; t_med = cyc; end
      end
      if (cd_env > 0) begin
        cd_env--;
        if (cd_env == 0) begin fim_envio = 1'b1; t_env = cyc; end
      end
      if (db_estado !== prev) begin
        got = {db_estado, zera, medir, erro};
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin n_err++; $display("FAIL nominal_trace: got %h want %h", got, want); end
        prev = db_estado;
      end
      if (medir) begin
        n_cmp++;
        if (cyc - t_mens != 2) begin n_err++; $display("FAIL lat_medir: got %0d want 2", cyc - t_mens); end
        cd_med = 20;
      end
      if (registra) begin
        n_cmp++;
        if (cyc - t_med != 1) begin n_err++; $display("FAIL lat_registra: got %0d want 1", cyc - t_med); end
      end
      if (partida) begin
        ws = exp_sel.size() != 0 ? exp_sel.pop_front() : 2'bxx;
        n_cmp++;
        if (sel_digito !== ws) begin n_err++; $display("FAIL nominal_sel: got %0d want %0d", sel_digito, ws); end
        if (t_env >= 0) begin
          n_cmp++;
          if (cyc - t_env != 2) begin n_err++; $display("FAIL lat_partida: got %0d want 2", cyc - t_env); end
        end
        cd_env = 10;
      end
    end
    fim_medida = 1'b0;
    fim_envio = 1'b0;
    n_cmp += 5;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL nominal_done: got %0d pending states want 0", exp_q.size()); end
    if (exp_sel.size() != 0) begin n_err++; $display("FAIL nominal_digits: got %0d pending digits want 0", exp_sel.size()); end
    if (n_partida - p0 != 4) begin n_err++; $display("FAIL partida_count: got %0d want 4", n_partida - p0); end
    if (n_conta - c0 != 3) begin n_err++; $display("FAIL conta_count: got %0d want 3", n_conta - c0); end
    if (n_pronto - r0 != 1) begin n_err++; $display("FAIL pronto_count: got %0d want 1", n_pronto - r0); end
    exp_q.delete();
    exp_sel.delete();
  endtask

  task automatic test_timeout();
    bit ok;
    int e, r0;
    logic [6:0] got, want;
    logic [3:0] prev;
    r0 = n_registra;
    @(negedge clock);
    mensurar = 1'b1;
    @(negedge clock);
    mensurar = 1'b0;
    wait_state(4'd3, 10, ok);
    e = cyc;
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL timeout_enter: got state %0d want 3", db_estado); end
    ok = 1'b0;
    for (int i = 0; i < 150 && !ok; i++) begin
      @(negedge clock);
      ok = erro === 1'b1;
    end
    n_cmp += 4;
    if (!ok) begin n_err++; $display("FAIL timeout_erro: got erro %b want 1", erro); end
    if (cyc - e != 100) begin n_err++; $display("FAIL timeout_cycles: got %0d want 100", cyc - e); end
    if (db_estado !== 4'd15) begin n_err++; $display("FAIL timeout_state: got %0d want 15", db_estado); end
    if (n_registra !== r0) begin n_err++; $display("FAIL timeout_registra: got %0d want %0d", n_registra, r0); end
    exp_q.push_back({4'd1, 1'b1, 1'b0, 1'b0});
    exp_q.push_back({4'd2, 1'b0, 1'b1, 1'b0});
    prev = db_estado;
    mensurar = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clock);
      mensurar = 1'b0;
      if (db_estado !== prev) begin
        got = {db_estado, zera, medir, erro};
        want = exp_q.pop_front();
        n_cmp++;
        if (got !== want) begin n_err++; $display("FAIL restart_trace: got %h want %h", got, want); end
        prev = db_estado;
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL restart_done: got %0d pending want 0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_simultaneous();
    bit ok;
    int e0;
    e0 = n_erro;
    wait_state(4'd3, 5, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL simul_enter: got state %0d want 3", db_estado); end
    repeat (99) @(negedge clock);
    fim_medida = 1'b1;
    @(negedge clock);
    fim_medida = 1'b0;
    n_cmp += 2;
    if (db_estado !== 4'd4 || registra !== 1'b1) begin
      n_err++; $display("FAIL simul_state: got %0d/%b want 4/1", db_estado, registra);
    end
    if (erro !== 1'b0) begin n_err++; $display("FAIL simul_erro: got %b want 0", erro); end
    finish_tx(ok);
    n_cmp += 2;
    if (!ok) begin n_err++; $display("FAIL simul_finish: got state %0d want 0", db_estado); end
    if (n_erro !== e0) begin n_err++; $display("FAIL simul_erro_count: got %0d want %0d", n_erro, e0); end
  endtask

  task automatic test_spurious();
    bit ok;
    int z0, m0;
    start_and_measure(ok);
    wait_state(4'd6, 10, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL spur_enter: got state %0d want 6", db_estado); end
    z0 = n_zera;
    m0 = n_medir;
    mensurar = 1'b1;
    @(negedge clock);
    mensurar = 1'b0;
    n_cmp++;
    if (db_estado !== 4'd6) begin n_err++; $display("FAIL spur_state: got %0d want 6", db_estado); end
    repeat (3) @(negedge clock);
    n_cmp++;
    if (db_estado !== 4'd6) begin n_err++; $display("FAIL spur_hold: got %0d want 6", db_estado); end
    finish_tx(ok);
    n_cmp += 2;
    if (!ok) begin n_err++; $display("FAIL spur_finish: got state %0d want 0", db_estado); end
    if (n_zera !== z0 || n_medir !== m0) begin
      n_err++; $display("FAIL spur_strobes: got %0d/%0d want %0d/%0d", n_zera, n_medir, z0, m0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int p0;
    start_and_measure(ok);
    wait_state(4'd6, 10, ok);
    fim_envio = 1'b1;
    @(negedge clock);
    fim_envio = 1'b0;
    wait_state(4'd6, 10, ok);
    n_cmp++;
    if (!ok || sel_digito !== 2'd1) begin n_err++; $display("FAIL rmid_enter: got %0d/%0d want 6/1", db_estado, sel_digito); end
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    n_cmp += 2;
    if (db_estado !== 4'd0) begin n_err++; $display("FAIL rmid_state: got %0d want 0", db_estado); end
    if (sel_digito !== 2'd2) begin n_err++; $display("FAIL rmid_sel: got %0d want 2", sel_digito); end
    p0 = n_partida;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      fim_envio = i % 3 == 0;
    end
    fim_envio = 1'b0;
    n_cmp += 2;
    if (n_partida !== p0) begin n_err++; $display("FAIL rmid_partida: got %0d want %0d", n_partida, p0); end
    if (db_estado !== 4'd0) begin n_err++; $display("FAIL rmid_idle: got %0d want 0", db_estado); end
  endtask

  initial begin
    test_reset();
    test_stray();
    test_nominal();
    test_timeout();
    test_simultaneous();
    test_spurious();
    test_reset_mid();
    test_nominal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
